debounce_filter: RTL

DEBOUNCE_FILTER -- requirements
Module: debounce_filter

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/input_synchronizer.sv | 28 ++
 rtl/debounce_filter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce filter.
//   state_t            : debounce FSM states
//   GLITCH_W           : width of the rejected-transition counter
//   DEF_SYNC_STAGES    : default synchronizer depth
//   DEF_STABLE_CYCLES  : default number of equal samples needed to accept a change
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  localparam int GLITCH_W          = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, clears every stage to 0
//   d    : raw asynchronous input
//   q    : synchronized output (last stage)
module input_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// Debounce filter: synchronizes a bouncy level input and only accepts a new
// level after STABLE_CYCLES consecutive equal synchronized samples. Rejected
// excursions are counted in a saturating counter.
// Ports:
//   clk        : clock, all state changes on posedge
//   rst        : synchronous active-high reset (priority over everything)
//   a          : raw, possibly asynchronous and bouncy, level input
//   glitch_clr : synchronous clear of glitch_cnt
//   filtered   : debounced level (registered)
//   rise       : one-cycle pulse on filtered 0->1 (registered)
//   fall       : one-cycle pulse on filtered 1->0 (registered)
//   glitch_cnt : saturating count of rejected transitions (registered)
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a,
  input  logic                glitch_clr,
  output logic                filtered,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  // Entering a WAIT state already counts the first differing sample, so the
  // change is accepted when the counter has reached STABLE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             a_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             glitch;

  input_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (a),
    .q  (a_s)
  );

  // A glitch is a WAIT state seeing the old level again before acceptance.
  assign glitch = ((state == RISE_WAIT) && !a_s) ||
                  ((state == FALL_WAIT) &&  a_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOW;
      cnt      <= '0;
      filtered <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        LOW: begin
          if (a_s) begin
            state <= RISE_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        RISE_WAIT: begin
          if (!a_s) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= HIGH;
            cnt      <= '0;
            filtered <= 1'b1;
            rise     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!a_s) begin
            state <= FALL_WAIT;
            cnt   <= CNT_ONE;
          end
        end
        FALL_WAIT: begin
          if (a_s) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= LOW;
            cnt      <= '0;
            filtered <= 1'b0;
            fall     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= LOW;
          cnt      <= '0;
          filtered <= 1'b0;
        end
      endcase
    end
  end

  // Clear wins over counting, but a glitch in the clear cycle is kept as 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= glitch ? GLITCH_W'(1) : '0;
    end else if (glitch && (glitch_cnt != GLITCH_MAX)) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end

endmodule
